linear_dequant_scheduler: RTL and testbench
===========================================

Name: linear_dequant_scheduler

Overview:
Sequences one full matrix-vector job through the linear dequant datapath. It walks the row / output-block / input-depth loop nest and issues one request per beat carrying data- and weight-buffer addresses plus first/last tags. It monitors the datapath's data_out_0 handshake to count completed output blocks, limits in-flight blocks with a credit counter, and signals job completion.

Parameters:
IN_DEPTH, 4, input chunks accumulated per output block (tensor_dim0 / parallelism_dim0 of data_in_0)
OUT_BLOCKS, 2, output blocks per row (out tensor_dim0 / out parallelism_dim0)
ROWS, 1, rows per job (in tensor_dim1 / parallelism_dim1)
MAX_OUTSTANDING, 2, max blocks issued but not yet retired; >=1
DATA_ADDR_WIDTH, $clog2(ROWS*IN_DEPTH)+1, data buffer address width
WEIGHT_ADDR_WIDTH, $clog2(OUT_BLOCKS*IN_DEPTH)+1, weight buffer address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset (0 = reset)
start  in  1  job start pulse; honoured only in IDLE
abort  in  1  synchronous abort; returns to IDLE next cycle
req_valid  out  1  request beat valid
req_ready  in  1  datapath/buffer accepts beat
req_data_addr  out  DATA_ADDR_WIDTH  row*IN_DEPTH + depth
req_weight_addr  out  WEIGHT_ADDR_WIDTH  blk*IN_DEPTH + depth
req_first  out  1  beat is depth==0 of a block
req_last  out  1  beat is depth==IN_DEPTH-1 of a block
out_valid  in  1  monitored data_out_0_valid
out_ready  in  1  monitored data_out_0_ready
busy  out  1  high in ISSUE or DRAIN
done  out  1  one-cycle pulse on job completion

Behaviour:
- Reset (rst=0, async): state=IDLE; all counters 0; req_valid=0, busy=0, done=0; address/tag outputs 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 -> ISSUE; row/blk/depth counters cleared. start in any other state is ignored.
- ISSUE: req_valid is high unless credit-stalled. A beat transfers on req_valid&req_ready. Outputs are registered and held stable while req_valid&!req_ready (AXI-style; no drop).
- Loop order per transfer: depth increments first; at depth==IN_DEPTH-1, depth->0 and blk++; at blk==OUT_BLOCKS-1 wrap, blk->0 and row++. A transfer of the final beat (last row, last blk, last depth) -> DRAIN.
- req_first = (depth==0); req_last = (depth==IN_DEPTH-1). With IN_DEPTH=1 both are high.
- Credit counter `outstanding`, width $clog2(MAX_OUTSTANDING+1):
  - +1 on transfer of a req_first beat.
  - -1 on out_valid&out_ready (retire).
  - Both in the same cycle -> unchanged.
- Credit stall: req_valid is forced 0 when the next beat has req_first=1 and outstanding==MAX_OUTSTANDING, judged on the registered count. A retire in the same cycle does not unblock until the next cycle.
- Retire counter counts out handshakes; total expected = ROWS*OUT_BLOCKS.
- DRAIN: req_valid=0. When the retire count reaches the total (including a retire in the current cycle) -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- busy = state is ISSUE or DRAIN.
- Retire while IDLE/DONE (spurious): ignored; counters do not underflow (saturate at 0).
- abort=1 in any state: next cycle IDLE, counters cleared, req_valid=0, no done pulse. abort has priority over start and over the final transfer.
- Reset mid-job: immediate IDLE; no partial done.

Decomposition:
- Package linear_sched_pkg: state enum (IDLE, ISSUE, DRAIN, DONE) and a function computing the counter width from a parameter.
- One sub-module is natural: nested_loop_counter (3-level wrap counter with enable, clear, and first/last/final flags), reused by other tile schedulers.
- Credit logic and FSM stay in the top module.

Test Plan:
- Defaults; start; req_ready=1 always; retire each block 3 cycles after its req_last -> 8 beats. Weight addresses 0..7, data addresses 0,1,2,3,0,1,2,3; first on beats 0 and 4, last on beats 3 and 7; done exactly once, after the 2nd retire.
- MAX_OUTSTANDING=1, no retire -> stalls after beat 3 (req_valid=0 at blk=1, depth=0). Retire one pulse -> beat 4 issues the following cycle.
- req_ready toggled 1,0,0,1 -> addresses and tags held constant during the low cycles; no beat skipped or duplicated.
- Retire coincident with a first-beat transfer when outstanding=1 (MAX=2) -> outstanding stays 1.
- abort asserted at beat 5 -> IDLE next cycle, req_valid=0, busy=0, no done. A new start restarts from address 0.
- rst pulled low mid-DRAIN -> outputs 0 immediately. start ignored while busy; a second start in DONE is ignored.

Source files
------------

// File: rtl/linear_sched_pkg.sv
// Shared types and helpers for the linear dequant tile schedulers.
package linear_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // Bits needed to hold indices 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/linear_dequant_scheduler_if.sv
// Request bus from the scheduler to the datapath buffers, plus the monitored
// data_out_0 handshake used to retire output blocks.
interface linear_dequant_scheduler_if #(
  parameter int DATA_ADDR_WIDTH   = 3,
  parameter int WEIGHT_ADDR_WIDTH = 4
);

  logic                         req_valid;
  logic                         req_ready;
  logic [DATA_ADDR_WIDTH-1:0]   req_data_addr;
  logic [WEIGHT_ADDR_WIDTH-1:0] req_weight_addr;
  logic                         req_first;
  logic                         req_last;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output req_valid, req_data_addr, req_weight_addr, req_first, req_last,
    input  req_ready, out_valid, out_ready
  );

  modport slave (
    input  req_valid, req_data_addr, req_weight_addr, req_first, req_last,
    output req_ready, out_valid, out_ready
  );

endinterface

// File: rtl/nested_loop_counter.sv
// Three-level wrap counter (inner idx0, middle idx1, outer idx2) with enable,
// synchronous clear and first/last flags for tile loop nests.
module nested_loop_counter
  import linear_sched_pkg::*;
#(
  parameter int N0 = 4,
  parameter int N1 = 2,
  parameter int N2 = 1,
  localparam int W0 = cnt_width(N0),
  localparam int W1 = cnt_width(N1),
  localparam int W2 = cnt_width(N2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  output logic [W0-1:0] idx0,
  output logic [W1-1:0] idx1,
  output logic [W2-1:0] idx2,
  output logic          first0,
  output logic          last0,
  output logic          all_last
);

  logic last1;
  logic last2;

  assign first0   = (idx0 == '0);
  assign last0    = (idx0 == W0'(N0 - 1));
  assign last1    = (idx1 == W1'(N1 - 1));
  assign last2    = (idx2 == W2'(N2 - 1));
  assign all_last = last0 && last1 && last2;

  // Advance the inner index each enabled beat and carry outward on wrap.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx0 <= '0;
      idx1 <= '0;
      idx2 <= '0;
    end else if (clear) begin
      idx0 <= '0;
      idx1 <= '0;
      idx2 <= '0;
    end else if (en) begin
      if (last0) begin
        idx0 <= '0;
        if (last1) begin
          idx1 <= '0;
          idx2 <= last2 ? '0 : idx2 + 1'b1;
        end else begin
          idx1 <= idx1 + 1'b1;
        end
      end else begin
        idx0 <= idx0 + 1'b1;
      end
    end
  end

endmodule

// File: rtl/linear_dequant_scheduler.sv
// Walks the row / output-block / input-depth loop nest of one matrix-vector
// job, issuing buffer address beats under a block credit limit, and retires
// blocks by watching the datapath output handshake.
module linear_dequant_scheduler
  import linear_sched_pkg::*;
#(
  parameter int IN_DEPTH          = 4,
  parameter int OUT_BLOCKS        = 2,
  parameter int ROWS              = 1,
  parameter int MAX_OUTSTANDING   = 2,
  parameter int DATA_ADDR_WIDTH   = $clog2(ROWS * IN_DEPTH) + 1,
  parameter int WEIGHT_ADDR_WIDTH = $clog2(OUT_BLOCKS * IN_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  linear_dequant_scheduler_if.master bus,
  output logic                      busy,
  output logic                      done
);

  localparam int DW    = cnt_width(IN_DEPTH);
  localparam int BW    = cnt_width(OUT_BLOCKS);
  localparam int RW    = cnt_width(ROWS);
  localparam int OW    = cnt_width(MAX_OUTSTANDING + 1);
  localparam int TOTAL = ROWS * OUT_BLOCKS;
  localparam int TW    = cnt_width(TOTAL + 1);

  sched_state_t  state;
  sched_state_t  state_nxt;

  logic [DW-1:0] depth;
  logic [BW-1:0] blk;
  logic [RW-1:0] row;
  logic          depth_first;
  logic          depth_last;
  logic          job_last;

  logic [OW-1:0] outstanding;
  logic [TW-1:0] retired;

  logic          xfer;
  logic          retire;
  logic          credit_stall;
  logic          job_clear;
  logic          retire_done;

  // Counters are held clear outside an active job, so a spurious retire in
  // IDLE/DONE never moves them and every job starts from address zero.
  assign job_clear    = abort || (state == IDLE) || (state == DONE);
  assign xfer         = bus.req_valid && bus.req_ready;
  assign retire       = bus.out_valid && bus.out_ready &&
                        ((state == ISSUE) || (state == DRAIN));
  // Judged on the registered count: a same-cycle retire frees the credit
  // only from the next cycle on.
  assign credit_stall = depth_first && (outstanding == OW'(MAX_OUTSTANDING));
  assign retire_done  = (retired == TW'(TOTAL)) ||
                        (retire && (retired == TW'(TOTAL - 1)));

  nested_loop_counter #(
    .N0 (IN_DEPTH),
    .N1 (OUT_BLOCKS),
    .N2 (ROWS)
  ) u_loop (
    .clk      (clk),
    .rst      (rst),
    .clear    (job_clear),
    .en       (xfer),
    .idx0     (depth),
    .idx1     (blk),
    .idx2     (row),
    .first0   (depth_first),
    .last0    (depth_last),
    .all_last (job_last)
  );

  // Addresses follow the loop registers, so they stay put while a beat waits.
  assign bus.req_data_addr   = DATA_ADDR_WIDTH'(int'(row) * IN_DEPTH + int'(depth));
  assign bus.req_weight_addr = WEIGHT_ADDR_WIDTH'(int'(blk) * IN_DEPTH + int'(depth));

  // Credit count: one taken per block opened, one returned per retire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
    end else if (job_clear) begin
      outstanding <= '0;
    end else begin
      case ({xfer && depth_first, retire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Count retired blocks of the current job, saturating at the job total.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired <= '0;
    end else if (job_clear) begin
      retired <= '0;
    end else if (retire && (retired != TW'(TOTAL))) begin
      retired <= retired + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; abort wins over start and over the final beat.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = ISSUE;
        ISSUE:   if (xfer && job_last) state_nxt = DRAIN;
        DRAIN:   if (retire_done) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decoded from the current state.
  // NOTE: every output gets a default before the case, so no path infers a latch.
  always_comb begin
    bus.req_valid = 1'b0;
    bus.req_first = 1'b0;
    bus.req_last  = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      ISSUE: begin
        bus.req_valid = !credit_stall;
        bus.req_first = depth_first;
        bus.req_last  = depth_last;
        busy          = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_linear_dequant_scheduler.sv
// Self-checking bench: a scoreboard of expected request beats is filled when
// a job is started and drained as the scheduler hands beats to the datapath.
module tb_linear_dequant_scheduler;

  localparam int IN_DEPTH   = 4;
  localparam int OUT_BLOCKS = 2;
  localparam int ROWS       = 1;
  localparam int DAW        = $clog2(ROWS * IN_DEPTH) + 1;
  localparam int WAW        = $clog2(OUT_BLOCKS * IN_DEPTH) + 1;
  localparam int BLOCKS     = ROWS * OUT_BLOCKS;

  typedef struct packed {
    logic [DAW-1:0] d;
    logic [WAW-1:0] w;
    logic           f;
    logic           l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b1, ov_a = 1'b0, or_a = 1'b1;
  logic busy_a, done_a;
  logic start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b1, ov_b = 1'b0, or_b = 1'b1;
  logic busy_b, done_b;

  linear_dequant_scheduler_if #(.DATA_ADDR_WIDTH(DAW), .WEIGHT_ADDR_WIDTH(WAW)) bus_a ();
  linear_dequant_scheduler_if #(.DATA_ADDR_WIDTH(DAW), .WEIGHT_ADDR_WIDTH(WAW)) bus_b ();

  assign bus_a.req_ready = ready_a;
  assign bus_a.out_valid = ov_a;
  assign bus_a.out_ready = or_a;
  assign bus_b.req_ready = ready_b;
  assign bus_b.out_valid = ov_b;
  assign bus_b.out_ready = or_b;

  linear_dequant_scheduler #(
    .IN_DEPTH (IN_DEPTH), .OUT_BLOCKS (OUT_BLOCKS), .ROWS (ROWS), .MAX_OUTSTANDING (2)
  ) dut (
    .clk (clk), .rst (rst), .start (start_a), .abort (abort_a),
    .bus (bus_a), .busy (busy_a), .done (done_a)
  );

  linear_dequant_scheduler #(
    .IN_DEPTH (IN_DEPTH), .OUT_BLOCKS (OUT_BLOCKS), .ROWS (ROWS), .MAX_OUTSTANDING (1)
  ) dut_m1 (
    .clk (clk), .rst (rst), .start (start_b), .abort (abort_b),
    .bus (bus_b), .busy (busy_b), .done (done_b)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc = 0;
  int unsigned beats_fired = 0;
  int unsigned retires_seen = 0;
  int unsigned done_cnt = 0;
  beat_t       exp_q[$];
  int unsigned retire_q[$];
  bit          auto_retire  = 1'b1;
  bit          coinc_mode   = 1'b0;
  bit          toggle_ready = 1'b0;
  logic [3:0]  ready_pat    = 4'b1001;   // cyc%4 = 0,1,2,3 -> 1,0,0,1

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic beat_t cur_beat_a();
    beat_t b;
    b.d = bus_a.req_data_addr;
    b.w = bus_a.req_weight_addr;
    b.f = bus_a.req_first;
    b.l = bus_a.req_last;
    return b;
  endfunction

  task automatic push_job();
    beat_t b;
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < OUT_BLOCKS; k++)
        for (int d = 0; d < IN_DEPTH; d++) begin
          b.d = DAW'(r * IN_DEPTH + d);
          b.w = WAW'(k * IN_DEPTH + d);
          b.f = (d == 0);
          b.l = (d == IN_DEPTH - 1);
          exp_q.push_back(b);
        end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One clock of instance A: score the beat offered now, step the edge,
  // then set up the retire and ready inputs for the new cycle.
  task automatic cycle();
    beat_t b, e;
    bit    fire, coinc, held;
    b     = cur_beat_a();
    fire  = bus_a.req_valid && ready_a;
    held  = bus_a.req_valid && !ready_a;
    coinc = 1'b0;
    if (fire) begin
      check("sb_nonempty", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat", b, e);
      end
      beats_fired++;
      if (coinc_mode && b.f && b.w != '0) begin
        ov_a  = 1'b1;
        coinc = 1'b1;
      end
      if (b.l && auto_retire && !(coinc_mode && b.w != WAW'(OUT_BLOCKS * IN_DEPTH - 1)))
        retire_q.push_back(cyc + 3);
    end
    if (ov_a && or_a) retires_seen++;
    tick();
    if (coinc) check("coinc_outstanding", dut.outstanding, 1);
    if (held) check("hold", {bus_a.req_valid, cur_beat_a()}, {1'b1, b});
    if (done_a) begin
      done_cnt++;
      check("done_after_retires", retires_seen, BLOCKS);
    end
    ov_a = 1'b0;
    if (retire_q.size() != 0 && retire_q[0] == cyc) begin
      void'(retire_q.pop_front());
      ov_a = 1'b1;
    end
    if (toggle_ready) ready_a = ready_pat[cyc % 4];
  endtask

  task automatic start_job();
    push_job();
    retire_q.delete();
    beats_fired = 0;
    start_a = 1'b1;
    cycle();
    start_a = 1'b0;
    retires_seen = 0;
    check("busy_after_start", busy_a, 1);
  endtask

  task automatic run_job(input bit start_in_done);
    int unsigned d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 80) begin
      cycle();
      n++;
    end
    check("job_done", done_cnt - d0, 1);
    start_a = start_in_done;
    cycle();
    start_a = 1'b0;
    check("post_done", {done_a, busy_a, bus_a.req_valid}, 0);
    cycle();
    check("idle_stays", busy_a, 0);
    check("done_once", done_cnt - d0, 1);
    check("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    int unsigned d0, n;

    // Reset values.
    #3;
    check("rst_outputs", {bus_a.req_valid, busy_a, done_a, cur_beat_a()}, 0);
    @(negedge clk) rst = 1'b1;
    tick();

    // Spurious retire while IDLE is ignored.
    ov_a = 1'b1;
    cycle();
    check("spurious_outstanding", dut.outstanding, 0);
    check("spurious_busy", busy_a, 0);

    // Basic job, ready always high, retire 3 cycles after each last beat.
    start_job();
    run_job(1'b0);

    // Credit stall with MAX_OUTSTANDING=1 on the second instance.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < IN_DEPTH; i++) begin
      check("b_beat", {bus_b.req_valid, bus_b.req_weight_addr}, {1'b1, WAW'(i)});
      tick();
    end
    check("b_stall", {bus_b.req_valid, bus_b.req_first, bus_b.req_weight_addr},
          {1'b0, 1'b1, WAW'(IN_DEPTH)});
    tick();
    check("b_stall_hold", {bus_b.req_valid, bus_b.req_weight_addr}, {1'b0, WAW'(IN_DEPTH)});
    ov_b = 1'b1;
    check("b_stall_retire_cycle", bus_b.req_valid, 0);
    tick();
    ov_b = 1'b0;
    check("b_resume", {bus_b.req_valid, bus_b.req_first, bus_b.req_weight_addr},
          {1'b1, 1'b1, WAW'(IN_DEPTH)});
    tick();
    check("b_next", {bus_b.req_valid, bus_b.req_weight_addr}, {1'b1, WAW'(IN_DEPTH + 1)});
    abort_b = 1'b1;
    tick();
    abort_b = 1'b0;
    check("b_abort", {bus_b.req_valid, busy_b, done_b}, 0);

    // Backpressure: ready pattern 1,0,0,1.
    toggle_ready = 1'b1;
    ready_a = ready_pat[cyc % 4];
    start_job();
    run_job(1'b0);
    toggle_ready = 1'b0;
    ready_a = 1'b1;

    // Retire coincident with the second block's first beat.
    coinc_mode = 1'b1;
    start_job();
    run_job(1'b0);
    coinc_mode = 1'b0;

    // Abort while beat 5 is offered, then restart from address 0.
    start_job();
    n = 0;
    while (beats_fired < 5 && n < 40) begin
      cycle();
      n++;
    end
    check("abort_reach_beat5", beats_fired, 5);
    d0 = done_cnt;
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    ov_a = 1'b0;
    exp_q.delete();
    retire_q.delete();
    check("abort_idle", {bus_a.req_valid, busy_a, done_a}, 0);
    for (int i = 0; i < 4; i++) cycle();
    check("abort_no_done", done_cnt - d0, 0);
    start_job();
    run_job(1'b0);

    // Reset asserted while draining.
    auto_retire = 1'b0;
    d0 = done_cnt;
    start_job();
    n = 0;
    while (beats_fired < BLOCKS * IN_DEPTH && n < 40) begin
      cycle();
      n++;
    end
    check("drain_entered", {busy_a, bus_a.req_valid}, {1'b1, 1'b0});
    cycle();
    check("drain_waits", busy_a, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_drain", {bus_a.req_valid, busy_a, done_a, cur_beat_a()}, 0);
    @(negedge clk) rst = 1'b1;
    tick();
    ov_a = 1'b0;
    exp_q.delete();
    retire_q.delete();
    check("rst_no_done", done_cnt - d0, 0);
    auto_retire = 1'b1;

    // start while busy is ignored; start during DONE is ignored.
    start_job();
    n = 0;
    while (beats_fired < 2 && n < 20) begin
      cycle();
      n++;
    end
    start_a = 1'b1;
    cycle();
    start_a = 1'b0;
    run_job(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
